matrix256_serial_rx: RTL

- Receive-side counterpart of the Pmod Matrix256 frame-buffer driver.
- Snoops the 3-wire shift-register link (sclk, serial_data, rclk) and rebuilds the 16x16 2-bit intensity image the driver is scanning out.
- Used as an on-FPGA loopback monitor and as the input stage of a daisy-chained second matrix board.
- Image is read back through a synchronous pixel port.

---
 rtl/matrix256_pkg.sv | 15 +
 rtl/matrix256_rx_sync.sv | 30 +++
 rtl/matrix256_serial_rx.sv | 129 ++++++++++++
 3 files changed

// File: rtl/matrix256_pkg.sv
// Shared geometry and types for the Pmod Matrix256 link receiver.
package matrix256_pkg;

  localparam int unsigned LINES     = 16;
  localparam int unsigned PIX       = 16;
  localparam int unsigned WORD_BITS = 32;
  localparam int unsigned ANODE_MSB = 31;
  localparam int unsigned CATH_MSB  = 15;
  localparam int unsigned CNT_W     = 6;

  typedef logic [1:0]       pix_t;
  typedef logic [3:0]       line_idx_t;
  typedef logic [CNT_W-1:0] bit_cnt_t;

endpackage

// File: rtl/matrix256_rx_sync.sv
// Multi-flop synchronizer for one asynchronous link wire, with registered
// level and rise/fall pulses that are all aligned to the same clk cycle.
module matrix256_rx_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] stages;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stages <= '0;
      level  <= 1'b0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      stages <= {stages[SYNC_STAGES-2:0], din};
      level  <= stages[SYNC_STAGES-1];
      rise   <= stages[SYNC_STAGES-1] & ~level;
      fall   <= ~stages[SYNC_STAGES-1] & level;
    end
  end

endmodule

// File: rtl/matrix256_serial_rx.sv
// Snoops the Matrix256 sclk/sdata/rclk link and rebuilds the 16x16 2-bit
// intensity image from the density passes the driver scans out.
module matrix256_serial_rx
  import matrix256_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned PASSES      = 4
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      link_sclk,
  input  logic      link_sdata,
  input  logic      link_rclk,
  input  logic [3:0] rd_line,
  input  logic [3:0] rd_pix,
  output logic [1:0] rd_data,
  output logic      line_commit,
  output logic [3:0] commit_line,
  output logic      frame_done,
  output logic      len_err,
  output logic      cath_err
);

  localparam int unsigned PW = (PASSES > 1) ? $clog2(PASSES) : 1;

  logic sclk_level, sclk_rise, sclk_fall;
  logic sdata_level, sdata_rise, sdata_fall;
  logic rclk_level, rclk_rise, rclk_fall;

  matrix256_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
    .clk(clk), .rst(rst), .din(link_sclk),
    .level(sclk_level), .rise(sclk_rise), .fall(sclk_fall)
  );
  matrix256_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sdata (
    .clk(clk), .rst(rst), .din(link_sdata),
    .level(sdata_level), .rise(sdata_rise), .fall(sdata_fall)
  );
  matrix256_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_rclk (
    .clk(clk), .rst(rst), .din(link_rclk),
    .level(rclk_level), .rise(rclk_rise), .fall(rclk_fall)
  );

  logic unused_sync;
  assign unused_sync = ^{sclk_level, sclk_rise, sdata_rise, sdata_fall,
                         rclk_level, rclk_fall};

  logic [WORD_BITS-1:0] word;
  bit_cnt_t             bit_cnt;
  pix_t                 acc      [LINES][PIX];
  pix_t                 disp     [LINES][PIX];
  logic [PW-1:0]        pass_cnt [LINES];

  logic [WORD_BITS-1:0] word_shift, word_eff;
  bit_cnt_t             cnt_shift, cnt_eff;
  logic                 cath_ok;
  line_idx_t            lat_line;
  pix_t                 acc_next [PIX];

  // Word/count as they stand once any same-cycle sclk bit is folded in.
  always_comb begin
    word_shift = {word[WORD_BITS-2:0], sdata_level};
    cnt_shift  = (bit_cnt == '1) ? bit_cnt : bit_cnt + bit_cnt_t'(1);
    word_eff   = sclk_fall ? word_shift : word;
    cnt_eff    = sclk_fall ? cnt_shift : bit_cnt;
    cath_ok    = ($countones(~word_eff[CATH_MSB:0]) == 1);
    lat_line   = '0;
    for (int l = 0; l < int'(LINES); l++) begin
      if (!word_eff[int'(CATH_MSB) - l]) lat_line = line_idx_t'(l);
    end
    for (int p = 0; p < int'(PIX); p++) begin
      if (word_eff[int'(ANODE_MSB) - int'(PIX) + 1 + p] && acc[lat_line][p] != 2'd3)
        acc_next[p] = acc[lat_line][p] + 2'd1;
      else
        acc_next[p] = acc[lat_line][p];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word        <= '0;
      bit_cnt     <= '0;
      rd_data     <= '0;
      line_commit <= 1'b0;
      commit_line <= '0;
      frame_done  <= 1'b0;
      len_err     <= 1'b0;
      cath_err    <= 1'b0;
      for (int l = 0; l < int'(LINES); l++) begin
        pass_cnt[l] <= '0;
        for (int p = 0; p < int'(PIX); p++) begin
          acc[l][p]  <= '0;
          disp[l][p] <= '0;
        end
      end
    end else begin
      line_commit <= 1'b0;
      frame_done  <= 1'b0;
      len_err     <= 1'b0;
      cath_err    <= 1'b0;
      rd_data     <= disp[rd_line][rd_pix];
      if (sclk_fall) begin
        word    <= word_shift;
        bit_cnt <= cnt_shift;
      end
      if (rclk_rise) begin
        bit_cnt <= '0;
        if (cnt_eff != bit_cnt_t'(WORD_BITS)) begin
          len_err <= 1'b1;
        end else if (!cath_ok) begin
          cath_err <= 1'b1;
        end else if (pass_cnt[lat_line] == PW'(PASSES - 1)) begin
          // Last density pass of this line: publish and restart accumulation.
          for (int p = 0; p < int'(PIX); p++) begin
            disp[lat_line][p] <= acc_next[p];
            acc[lat_line][p]  <= '0;
          end
          pass_cnt[lat_line] <= '0;
          line_commit        <= 1'b1;
          commit_line        <= lat_line;
          frame_done         <= (lat_line == line_idx_t'(LINES - 1));
        end else begin
          for (int p = 0; p < int'(PIX); p++) acc[lat_line][p] <= acc_next[p];
          pass_cnt[lat_line] <= pass_cnt[lat_line] + PW'(1);
        end
      end
    end
  end

endmodule
